// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the configuration stream loader.
// Purpose: holds the loader FSM state type, the config_addr field layout
// and the default reserved bus addresses. The top level and the record
// assembler both import this package.
// Ports: none (package).
package config_stream_loader_pkg;

    // Loader FSM states: collect a record, present it on the bus, or sit
    // finished after the END record.
    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } loader_state_t;

    // Field layout of config_addr as seen by the tiles.
    localparam int TILE_ID_LSB = 0;
    localparam int TILE_ID_MSB = 15;
    localparam int MOD_ID_LSB  = 16;
    localparam int MOD_ID_MSB  = 31;

    // mod_id 0 matches no module, so an all-zero address is a safe idle value.
    localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'h0000_0000;
    // Address value that marks the end of the bitstream.
    localparam logic [31:0] DEFAULT_END_ADDR  = 32'hFFFF_FFFF;

    // One record is four address bytes followed by four data bytes.
    localparam int RECORD_BYTES = 8;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/config_stream_loader_record_assembler.sv
// config_record_assembler
// Purpose: collects the byte stream into 8-byte (address, data) records.
// Bytes arrive little-endian: bytes 0..3 form the address, 4..7 the data.
// record_valid pulses in the same cycle the eighth byte is accepted; the
// record outputs are valid only during that pulse, with the final byte
// merged in combinationally so the consumer can register the whole record
// on the very edge that accepts it.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   in_data       - stream byte
//   byte_accept   - a byte is being accepted this cycle
//   record_valid  - eighth byte of a record accepted this cycle
//   record_addr   - assembled 32-bit address (valid with record_valid)
//   record_data   - assembled 32-bit data    (valid with record_valid)
module config_record_assembler
    import config_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        byte_accept,
    output logic        record_valid,
    output logic [31:0] record_addr,
    output logic [31:0] record_data
);

    localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES - 1);

    logic [2:0]  byte_count;
    logic [55:0] shift_reg;

    // Bytes shift in at the top so that after seven bytes byte 0 sits in
    // bits [7:0]. The counter simply wraps after the eighth byte; the next
    // record fully overwrites the shift register before it is used again.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count <= 3'd0;
            shift_reg  <= 56'd0;
        end else if (byte_accept) begin
            byte_count <= byte_count + 3'd1;
            shift_reg  <= {in_data, shift_reg[55:8]};
        end
    end

    assign record_valid = byte_accept && (byte_count == LAST_BYTE);
    assign record_addr  = shift_reg[31:0];
    assign record_data  = {in_data, shift_reg[55:32]};

endmodule

// File: rtl/config_stream_loader.sv
// config_stream_loader
// Purpose: configuration master for the tile array. Assembles (address,
// data) records from a byte stream and presents each one on the broadcast
// config bus for HOLD_CYCLES cycles. An END_ADDR record stops programming
// until start re-arms the loader.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   in_data       - stream byte
//   in_valid      - stream byte valid
//   in_ready      - loader accepts a byte this cycle (RECV only)
//   start         - re-arm pulse, honoured only after completion
//   config_addr   - bus address: [15:0] tile_id, [31:16] mod_id
//   config_data   - bus data (holds its last written value)
//   config_write  - high while a write is presented
//   config_done   - END record received
//   write_count   - writes issued since arm (saturating)
module config_stream_loader
    import config_stream_loader_pkg::*;
#(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = DEFAULT_IDLE_ADDR,
    parameter logic [31:0] END_ADDR    = DEFAULT_END_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_write,
    output logic        config_done,
    output logic [15:0] write_count
);

    // Hold counter runs 0..HOLD_CYCLES-1 while in WRITE.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    loader_state_t state;
    loader_state_t state_next;

    logic [7:0]  hold_count;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [15:0] write_count_reg;

    logic        byte_accept;
    logic        record_valid;
    logic [31:0] record_addr;
    logic [31:0] record_data;
    logic        record_is_end;
    logic        hold_last;

    assign byte_accept   = in_valid && in_ready;
    assign record_is_end = (record_addr == END_ADDR);
    assign hold_last     = (hold_count == HOLD_LAST);

    config_record_assembler u_assembler (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .byte_accept  (byte_accept),
        .record_valid (record_valid),
        .record_addr  (record_addr),
        .record_data  (record_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RECV;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A completed record goes straight to WRITE (or DONE
    // for the END record) so the bus sees it one cycle after the last byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_RECV: begin
                if (record_valid) begin
                    state_next = record_is_end ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (hold_last) begin
                    state_next = ST_RECV;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RECV;
                end
            end
            default: state_next = ST_RECV;
        endcase
    end

    // Datapath registers. The record is captured on the same edge that
    // moves the FSM into WRITE; write_count advances on the edge that ends
    // the hold window. The END record is never captured, so config_data
    // keeps the last real write.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_count      <= 8'd0;
            addr_reg        <= IDLE_ADDR;
            data_reg        <= 32'd0;
            write_count_reg <= 16'd0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (record_valid && !record_is_end) begin
                        addr_reg   <= record_addr;
                        data_reg   <= record_data;
                        hold_count <= 8'd0;
                    end
                end
                ST_WRITE: begin
                    if (hold_last) begin
                        write_count_reg <= sat_inc16(write_count_reg);
                    end else begin
                        hold_count <= hold_count + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        write_count_reg <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode. The address is gated by state so that any exit from
    // WRITE, including reset, returns the bus to IDLE_ADDR on that edge.
    always_comb begin
        in_ready     = 1'b0;
        config_write = 1'b0;
        config_done  = 1'b0;
        config_addr  = IDLE_ADDR;
        case (state)
            ST_RECV: begin
                in_ready = 1'b1;
            end
            ST_WRITE: begin
                config_write = 1'b1;
                config_addr  = addr_reg;
            end
            ST_DONE: begin
                config_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign config_data = data_reg;
    assign write_count = write_count_reg;

endmodule

// File: tb/tb_config_stream_loader.sv
// Testbench for config_stream_loader.
// Three instances with HOLD_CYCLES of 1, 3 and 4 share clock, reset, data
// and start; each has its own in_valid so records are steered to one
// instance at a time. Expected values are hand-computed constants.
module tb_config_stream_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        start;
    logic        valid1, valid3, valid4;

    logic        ready1, ready3, ready4;
    logic [31:0] addr1, addr3, addr4;
    logic [31:0] data1, data3, data4;
    logic        write1, write3, write4;
    logic        done1, done3, done4;
    logic [15:0] count1, count3, count4;

    int checkCount = 0;
    int passCount  = 0;

    config_stream_loader #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid1),
        .in_ready(ready1), .start(start), .config_addr(addr1),
        .config_data(data1), .config_write(write1), .config_done(done1),
        .write_count(count1)
    );

    config_stream_loader #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid3),
        .in_ready(ready3), .start(start), .config_addr(addr3),
        .config_data(data3), .config_write(write3), .config_done(done3),
        .write_count(count3)
    );

    config_stream_loader #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid4),
        .in_ready(ready4), .start(start), .config_addr(addr4),
        .config_data(data4), .config_write(write4), .config_done(done4),
        .write_count(count4)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive one byte to the selected instance for one edge, then drop valid.
    task automatic applyStimulus(input int which, input logic [7:0] b);
        in_data = b;
        valid1  = (which == 1);
        valid3  = (which == 3);
        valid4  = (which == 4);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid3 = 1'b0;
        valid4 = 1'b0;
    endtask

    // Record packed as {data, addr}; byte i of the stream is rec[8*i +: 8].
    task automatic sendRecord(input int which, input logic [63:0] rec);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(which, rec[8*i +: 8]);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] toggleRec;
        reset   = 1'b1;
        in_data = 8'h00;
        start   = 1'b0;
        valid1  = 1'b0;
        valid3  = 1'b0;
        valid4  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        checkOutput("rst_addr",  addr1,  32'h0);
        checkOutput("rst_data",  data1,  32'h0);
        checkOutput("rst_write", write1, 1'b0);
        checkOutput("rst_done",  done1,  1'b0);
        checkOutput("rst_count", count1, 16'd0);
        checkOutput("rst_ready", ready1, 1'b1);

        // Basic record, HOLD_CYCLES=1.
        sendRecord(1, {32'h0000_0005, 32'h0001_0001});
        checkOutput("h1_addr",  addr1,  32'h0001_0001);
        checkOutput("h1_data",  data1,  32'h0000_0005);
        checkOutput("h1_write", write1, 1'b1);
        checkOutput("h1_ready", ready1, 1'b0);
        idleCycles(1);
        checkOutput("h1_addr_idle", addr1,  32'h0);
        checkOutput("h1_write_off", write1, 1'b0);
        checkOutput("h1_count",     count1, 16'd1);
        checkOutput("h1_data_hold", data1,  32'h0000_0005);
        checkOutput("h1_ready_back", ready1, 1'b1);

        // Same record, HOLD_CYCLES=3: three stable write cycles.
        sendRecord(3, {32'h0000_0005, 32'h0001_0001});
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("h3_write_c%0d", c), write3, 1'b1);
            checkOutput($sformatf("h3_addr_c%0d", c),  addr3,  32'h0001_0001);
            checkOutput($sformatf("h3_data_c%0d", c),  data3,  32'h0000_0005);
            checkOutput($sformatf("h3_ready_c%0d", c), ready3, 1'b0);
            idleCycles(1);
        end
        checkOutput("h3_write_off", write3, 1'b0);
        checkOutput("h3_addr_idle", addr3,  32'h0);
        checkOutput("h3_count",     count3, 16'd1);

        // in_valid toggling: one idle cycle between every byte.
        toggleRec = {32'hDEAD_BEEF, 32'h1234_5678};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, toggleRec[8*i +: 8]);
            if (i < 7) begin
                idleCycles(1);
            end
            if (i == 6) begin
                checkOutput("tog_no_early_write", write1, 1'b0);
                checkOutput("tog_still_ready",    ready1, 1'b1);
            end
        end
        checkOutput("tog_addr",  addr1,  32'h1234_5678);
        checkOutput("tog_data",  data1,  32'hDEAD_BEEF);
        checkOutput("tog_write", write1, 1'b1);
        idleCycles(1);
        checkOutput("tog_count", count1, 16'd2);

        // start outside DONE is ignored.
        pulseStart();
        checkOutput("start_ignored_count", count1, 16'd2);
        checkOutput("start_ignored_done",  done1,  1'b0);

        // END record: no write, loader parks in DONE.
        sendRecord(1, {32'hA5A5_A5A5, 32'hFFFF_FFFF});
        checkOutput("end_write", write1, 1'b0);
        checkOutput("end_done",  done1,  1'b1);
        checkOutput("end_ready", ready1, 1'b0);
        checkOutput("end_addr",  addr1,  32'h0);
        checkOutput("end_data_kept", data1, 32'hDEAD_BEEF);
        idleCycles(2);
        checkOutput("end_done_held", done1,  1'b1);
        checkOutput("end_count",     count1, 16'd2);
        pulseStart();
        checkOutput("rearm_done",  done1,  1'b0);
        checkOutput("rearm_count", count1, 16'd0);
        checkOutput("rearm_ready", ready1, 1'b1);

        // Reset after five bytes discards the partial record.
        applyStimulus(4, 8'hAA);
        applyStimulus(4, 8'hBB);
        applyStimulus(4, 8'hCC);
        applyStimulus(4, 8'hDD);
        applyStimulus(4, 8'hEE);
        pulseReset();
        checkOutput("mid_rst_ready", ready4, 1'b1);
        checkOutput("mid_rst_write", write4, 1'b0);
        sendRecord(4, {32'h1122_3344, 32'h0003_0002});
        checkOutput("fresh_addr",  addr4,  32'h0003_0002);
        checkOutput("fresh_data",  data4,  32'h1122_3344);
        checkOutput("fresh_write", write4, 1'b1);
        idleCycles(3);
        checkOutput("fresh_write_c4", write4, 1'b1);
        idleCycles(1);
        checkOutput("fresh_write_off", write4, 1'b0);
        checkOutput("fresh_count",     count4, 16'd1);

        // Reset on the first WRITE cycle, HOLD_CYCLES=4.
        sendRecord(4, {32'h0000_0007, 32'h0004_0005});
        checkOutput("wr_rst_pre_write", write4, 1'b1);
        pulseReset();
        checkOutput("wr_rst_write", write4, 1'b0);
        checkOutput("wr_rst_addr",  addr4,  32'h0);
        checkOutput("wr_rst_count", count4, 16'd0);
        checkOutput("wr_rst_ready", ready4, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
